// File: rtl/imem_ws.sv
// imem_ws: writable instruction memory with wait states and a valid/ready fetch handshake.
// Unwritten or out-of-range words read as zero; out-of-range fetches also flag rsp_err.
module imem_ws #(
    parameter int N     = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_err,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_mem [DEPTH];
    logic [N-1:0]  r_rsp_data;
    logic          r_rsp_err;
    logic          w_rd_ok;
    logic          w_wr_ok;
    assign w_rd_ok   = 32'(r_addr) < 32'(DEPTH);
    assign w_wr_ok   = 32'(wr_addr) < 32'(DEPTH);
    assign req_ready = r_state == S_IDLE;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    // Every fetch spends at least one cycle in S_WAIT, so capture lands WAIT+1 edges after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (wr_en && w_wr_ok) r_mem[wr_addr] <= wr_data;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_state <= S_WAIT;
                    r_addr  <= req_addr;
                    r_cnt   <= 4'(WAIT);
                end
                S_WAIT: if (r_cnt == 4'd0) begin
                    r_state    <= S_RESP;
                    r_rsp_data <= w_rd_ok ? r_mem[r_addr] : '0;
                    r_rsp_err  <= !w_rd_ok;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: if (rsp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
